// File: rtl/mc_decode_pkg.sv
// Shared encodings for the multi-cycle instruction decoder.
// MC_DECODE_MUL_EN, when defined, enables the MULEX multiply sequencing.
package mc_decode_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_MULEX  = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MUL    = 2'b11;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

`ifdef MC_DECODE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic       alu_op;
    logic       branch;
    logic       mul_start;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       arith;
    logic [2:0] code;
  } alu_dec_t;

  // arith marks the commands whose carry/overflow flags are meaningful
  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d = '{valid: 1'b1, arith: 1'b0, code: ALU_ADD};
    case (cmd)
      CMD_ADD: begin d.code = ALU_ADD; d.arith = 1'b1; end
      CMD_SUB: begin d.code = ALU_SUB; d.arith = 1'b1; end
      CMD_CMP: begin d.code = ALU_SUB; d.arith = 1'b1; end
      CMD_AND: d.code = ALU_AND;
      CMD_ORR: d.code = ALU_ORR;
      CMD_EOR: d.code = ALU_EOR;
      CMD_MOV: d.code = ALU_MOV;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_decode_fsm.sv
// Main controller FSM: state register, multiply down-counter, Moore output table.
// MULEX is reachable only when MC_DECODE_MUL_EN is defined.
//
//   state  | meaning
//   FETCH  | read instruction, PC += 4
//   DECODE | read registers, precompute PC + 8
//   MEMADR | compute load/store address
//   MEMRD  | read data memory
//   MEMWB  | write loaded data to Rd
//   MEMWR  | write data memory
//   EXECR  | ALU op, register operand
//   EXECI  | ALU op, immediate operand
//   ALUWB  | write ALU (or multiplier) result to Rd
//   BRANCH | compute branch target
//   MULEX  | wait for multiplier
module mc_decode_fsm
  import mc_decode_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_op,
  input  logic [1:0] i_funct_hi,
  input  logic       i_s_bit,
  input  logic [3:0] i_op2,
  input  logic       i_no_write,
  output ctrl_t      o_ctrl,
  output state_t     o_state
);

  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_mul_cnt;
  logic       r_from_mul;
  logic       w_is_mul;

  assign w_is_mul = MUL_EN && (i_op == 2'b00) && (i_funct_hi == 2'b00) && (i_op2 == 4'b1001);
  assign o_state  = r_state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_mul_cnt  <= 4'd0;
      r_from_mul <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_from_mul <= (r_state == S_MULEX);
      if ((w_next == S_MULEX) && (r_state != S_MULEX)) begin
        r_mul_cnt <= MulLoad;
      end else if ((r_state == S_MULEX) && (r_mul_cnt != 4'd0)) begin
        r_mul_cnt <= r_mul_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (i_op)
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          2'b11:   w_next = S_FETCH;
          default: begin
            if (w_is_mul)           w_next = S_MULEX;
            else if (i_funct_hi[1]) w_next = S_EXECI;
            else                    w_next = S_EXECR;
          end
        endcase
      end
      S_MEMADR: w_next = i_s_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI:  w_next = i_no_write ? S_FETCH : S_ALUWB;
      S_MULEX:  w_next = (r_mul_cnt == 4'd0) ? S_ALUWB : S_MULEX;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    o_ctrl            = '0;
    o_ctrl.result_src = RES_ALUOUT;
    o_ctrl.alu_src_a  = SRCA_REG;
    o_ctrl.alu_src_b  = SRCB_REG;
    case (r_state)
      S_FETCH: begin
        o_ctrl.ir_write   = 1'b1;
        o_ctrl.next_pc    = 1'b1;
        o_ctrl.alu_src_a  = SRCA_PC;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a  = SRCA_PC;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
      end
      S_MEMADR: o_ctrl.alu_src_b = SRCB_IMM;
      S_MEMRD:  o_ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        o_ctrl.result_src = RES_DATA;
        o_ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.adr_src = 1'b1;
        o_ctrl.mem_w   = 1'b1;
      end
      S_EXECR: o_ctrl.alu_op = 1'b1;
      S_EXECI: begin
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.result_src = (MUL_EN && r_from_mul) ? RES_MUL : RES_ALUOUT;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = SRCA_ALUOUT;
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.branch     = 1'b1;
      end
      // counter still holds its load value only in the first MULEX cycle
      S_MULEX: o_ctrl.mul_start = MUL_EN && (r_mul_cnt == MulLoad);
      default: ;
    endcase
    if (i_reset) begin
      o_ctrl.ir_write  = 1'b0;
      o_ctrl.next_pc   = 1'b0;
      o_ctrl.reg_w     = 1'b0;
      o_ctrl.mem_w     = 1'b0;
      o_ctrl.mul_start = 1'b0;
    end
  end

endmodule

// File: rtl/mc_decode.sv
// Multi-cycle decoder top: ALU decode, PC-write logic and instruction-field decode.
// MC_DECODE_MUL_EN (see mc_decode_pkg) enables multiply sequencing.
module mc_decode
  import mc_decode_pkg::*;
#(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [1:0]           i_op,
  input  logic [5:0]           i_funct,
  input  logic [3:0]           i_rd,
  input  logic [3:0]           i_op2,
  output logic [1:0]           o_flag_w,
  output logic                 o_pcs,
  output logic                 o_next_pc,
  output logic                 o_reg_w,
  output logic                 o_mem_w,
  output logic                 o_ir_write,
  output logic                 o_adr_src,
  output logic [1:0]           o_result_src,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_imm_src,
  output logic [1:0]           o_reg_src,
  output logic [ALUCTRL_W-1:0] o_alu_control,
  output logic                 o_mul_start,
  output logic [3:0]           o_state
);

  ctrl_t    w_ctrl;
  state_t   w_state;
  alu_dec_t w_alu;
  logic     w_no_write;

  assign w_alu      = alu_decode(i_funct[4:1]);
  assign w_no_write = !w_alu.valid || (i_funct[4:1] == CMD_CMP);

  mc_decode_fsm #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_fsm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_op       (i_op),
    .i_funct_hi (i_funct[5:4]),
    .i_s_bit    (i_funct[0]),
    .i_op2      (i_op2),
    .i_no_write (w_no_write),
    .o_ctrl     (w_ctrl),
    .o_state    (w_state)
  );

  always_comb begin
    o_alu_control = '0;
    o_flag_w      = 2'b00;
    if (w_ctrl.alu_op && w_alu.valid) begin
      o_alu_control[2:0] = w_alu.code;
      o_flag_w           = {i_funct[0], i_funct[0] & w_alu.arith};
    end
  end

  assign o_pcs        = ((i_rd == 4'hF) & w_ctrl.reg_w) | w_ctrl.branch;
  assign o_imm_src    = i_op;
  assign o_reg_src    = {i_op == 2'b01, i_op == 2'b10};

  assign o_next_pc    = w_ctrl.next_pc;
  assign o_reg_w      = w_ctrl.reg_w;
  assign o_mem_w      = w_ctrl.mem_w;
  assign o_ir_write   = w_ctrl.ir_write;
  assign o_adr_src    = w_ctrl.adr_src;
  assign o_result_src = w_ctrl.result_src;
  assign o_alu_src_a  = w_ctrl.alu_src_a;
  assign o_alu_src_b  = w_ctrl.alu_src_b;
  assign o_mul_start  = w_ctrl.mul_start;
  assign o_state      = w_state;

endmodule

// File: tb/tb_mc_decode.sv
// Scoreboard bench for mc_decode: per-instruction expected cycle records vs. sampled outputs.
`timescale 1ns/1ps
module tb_mc_decode;
  import mc_decode_pkg::*;

  localparam int ALUCTRL_W  = 4;
  localparam int MUL_CYCLES = 4;
`ifdef MC_DECODE_MUL_EN
  localparam bit TB_MUL = 1'b1;
`else
  localparam bit TB_MUL = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           op;
  logic [5:0]           funct;
  logic [3:0]           rd;
  logic [3:0]           op2;
  logic [1:0]           flag_w, result_src, alu_src_a, alu_src_b, imm_src, reg_src;
  logic                 pcs, next_pc, reg_w, mem_w, ir_write, adr_src, mul_start;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [3:0]           state;

  always #5 clk = ~clk;

  mc_decode #(.ALUCTRL_W(ALUCTRL_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_rd(rd), .i_op2(op2),
    .o_flag_w(flag_w), .o_pcs(pcs), .o_next_pc(next_pc), .o_reg_w(reg_w), .o_mem_w(mem_w),
    .o_ir_write(ir_write), .o_adr_src(adr_src), .o_result_src(result_src),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_imm_src(imm_src),
    .o_reg_src(reg_src), .o_alu_control(alu_control), .o_mul_start(mul_start),
    .o_state(state)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       ir_write, next_pc, reg_w, mem_w, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, reg_src;
    logic [3:0] alu_control;
    logic [1:0] flag_w;
    logic       pcs, mul_start;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  function automatic obs_t sample();
    obs_t a;
    a.state = state; a.ir_write = ir_write; a.next_pc = next_pc; a.reg_w = reg_w;
    a.mem_w = mem_w; a.adr_src = adr_src; a.result_src = result_src;
    a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.imm_src = imm_src;
    a.reg_src = reg_src; a.alu_control = alu_control; a.flag_w = flag_w;
    a.pcs = pcs; a.mul_start = mul_start;
    return a;
  endfunction

  // Expected outputs for one cycle, straight from the state output table and ALU rules.
  function automatic obs_t expect_step(logic [3:0] st, bit first_mul, bit after_mul,
                                       logic [1:0] o, logic [5:0] f, logic [3:0] r);
    obs_t e;
    bit   alu_active = 1'b0;
    bit   branch = 1'b0;
    bit   known = 1'b1;
    bit   arith = 1'b0;
    int   code = 0;
    e = '0;
    e.state = st;
    case (st)
      S_FETCH:  begin e.ir_write = 1; e.next_pc = 1; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      S_DECODE: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      S_MEMADR: e.alu_src_b = 2'b01;
      S_MEMRD:  e.adr_src = 1;
      S_MEMWB:  begin e.result_src = 2'b01; e.reg_w = 1; end
      S_MEMWR:  begin e.adr_src = 1; e.mem_w = 1; end
      S_EXECR:  alu_active = 1;
      S_EXECI:  begin e.alu_src_b = 2'b01; alu_active = 1; end
      S_ALUWB:  begin e.reg_w = 1; e.result_src = after_mul ? 2'b11 : 2'b00; end
      S_BRANCH: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.result_src = 2'b10; branch = 1; end
      S_MULEX:  e.mul_start = first_mul;
      default:  ;
    endcase
    if (alu_active) begin
      case (f[4:1])
        4'b0100: begin code = 0; arith = 1; end
        4'b0010: begin code = 1; arith = 1; end
        4'b0000: code = 2;
        4'b1100: code = 3;
        4'b0001: code = 4;
        4'b1101: code = 5;
        4'b1010: begin code = 1; arith = 1; end
        default: known = 0;
      endcase
      if (known) begin
        e.alu_control = 4'(code);
        e.flag_w = {f[0], f[0] & arith};
      end
    end
    e.imm_src = o;
    e.reg_src = {o == 2'b01, o == 2'b10};
    e.pcs = ((r == 4'hF) && e.reg_w) || branch;
    return e;
  endfunction

  function automatic obs_t reset_expect(logic [1:0] o);
    obs_t e;
    e = '0;
    e.state = S_FETCH; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    e.imm_src = o; e.reg_src = {o == 2'b01, o == 2'b10};
    return e;
  endfunction

  // Builds the instruction's state walk and queues the first `keep` cycle records.
  task automatic plan(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                      input logic [3:0] m, input int keep,
                      output int n, output logic [3:0] st_at_keep);
    logic [3:0] path[$];
    bit         no_write;
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    if (o == 2'b01) begin
      path.push_back(S_MEMADR);
      if (f[0]) begin path.push_back(S_MEMRD); path.push_back(S_MEMWB); end
      else path.push_back(S_MEMWR);
    end else if (o == 2'b10) begin
      path.push_back(S_BRANCH);
    end else if (o == 2'b00) begin
      if (TB_MUL && f[5:4] == 2'b00 && m == 4'b1001) begin
        for (int i = 0; i < MUL_CYCLES; i++) path.push_back(S_MULEX);
        path.push_back(S_ALUWB);
      end else begin
        path.push_back(f[5] ? S_EXECI : S_EXECR);
        no_write = !(f[4:1] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101})
                   || f[4:1] == 4'b1010;
        if (!no_write) path.push_back(S_ALUWB);
      end
    end
    n = path.size();
    st_at_keep = (keep < n) ? path[keep] : 4'(S_FETCH);
    for (int i = 0; i < n && i < keep; i++) begin
      bit fm, am;
      fm = (path[i] == S_MULEX) && (path[i-1] != S_MULEX);
      am = (path[i] == S_ALUWB) && (path[i-1] == S_MULEX);
      exp_q.push_back(expect_step(path[i], fm, am, o, f, r));
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] m);
    int n;
    logic [3:0] dummy;
    op = o; funct = f; rd = r; op2 = m;
    plan(o, f, r, m, 1000, n, dummy);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_obs(input string name, input obs_t e);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (state %0d vs %0d)", name, a, e, a.state, e.state);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        checks++;
        step_no++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_%0d: actual=%h required=%h (state %0d vs %0d)",
                   step_no, a, e, a.state, e.state);
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  logic [3:0] cmds[7] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010};

  initial begin : stim
    int         n;
    int         sel;
    logic [3:0] st3;
    logic [1:0] r_op;
    logic [5:0] r_funct;
    logic [3:0] r_rd, r_op2;

    reset = 1'b1; op = 2'b10; funct = 6'd0; rd = 4'd0; op2 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_obs("reset_hold", reset_expect(2'b10));
    reset = 1'b0;

    run_instr(2'b00, 6'b001001, 4'd1,  4'b0000);   // ADDS R1
    run_instr(2'b00, 6'b010101, 4'd3,  4'b0000);   // CMP
    run_instr(2'b01, 6'b011001, 4'd15, 4'b0000);   // LDR PC
    run_instr(2'b00, 6'b000000, 4'd2,  4'b1001);   // MUL
    run_instr(2'b10, 6'b000000, 4'd0,  4'b0000);   // B
    run_instr(2'b01, 6'b011000, 4'd4,  4'b0000);   // STR
    run_instr(2'b00, 6'b101000, 4'd15, 4'b1001);   // ADD imm to PC, not a multiply
    run_instr(2'b11, 6'b111111, 4'd15, 4'b1001);
    run_instr(2'b00, 6'b000111, 4'd5,  4'b0000);   // undefined cmd

    // reset in the 4th cycle of a multiply (2nd MULEX when multiply is enabled)
    op = 2'b00; funct = 6'b000000; rd = 4'd15; op2 = 4'b1001;
    plan(2'b00, 6'b000000, 4'd15, 4'b1001, 3, n, st3);
    repeat (3) begin @(posedge clk); #1; end
    check_val("pre_reset_state", int'(state), int'(st3));
    reset = 1'b1;
    #1;
    check_obs("reset_mid_instr", reset_expect(2'b00));
    @(posedge clk); #1;
    check_obs("reset_held", reset_expect(2'b00));
    reset = 1'b0;
    run_instr(2'b00, 6'b001001, 4'd1, 4'b0000);
    run_instr(2'b00, 6'b000000, 4'd15, 4'b1001);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      r_op = (sel < 2) ? 2'b01 : (sel == 2) ? 2'b10 : (sel == 3) ? 2'b11 : 2'b00;
      r_funct = 6'($urandom);
      r_op2 = 4'($urandom);
      r_rd = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if (r_op == 2'b00 && $urandom_range(0, 3) != 0) r_funct[4:1] = cmds[$urandom_range(0, 6)];
      if (r_op == 2'b00 && $urandom_range(0, 3) == 0) begin
        r_funct[5:4] = 2'b00;
        r_op2 = 4'b1001;
      end
      run_instr(r_op, r_funct, r_rd, r_op2);
    end

    @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
